// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock programmable FIFO.
//   fifo_mode_e : read-port behaviour (registered read or first-word-fall-through)
//   fifo_depth  : number of entries for a given address width
package fifo_pkg;

  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

  function automatic int fifo_depth(input int asize);
    return 1 << asize;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo_prog.
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset (clears the registered read word only)
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable (registered read mode only)
//   raddr  in   read address
//   rdata  out  read data: registered on re (FIFO_STD) or combinational (FIFO_FWFT)
module sync_fifo_mem
  import fifo_pkg::*;
#(
  parameter int         DSIZE = 8,
  parameter int         ASIZE = 3,
  parameter fifo_mode_e MODE  = FIFO_STD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             re,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ASIZE);

  // The array itself carries no reset: emptiness is tracked by the pointers.
  logic [DSIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  if (MODE == FIFO_FWFT) begin : g_async_rd
    assign rdata = mem[raddr];
  end else begin : g_reg_rd
    // Read stage boundary: word leaves the array one cycle after re.
    logic [DSIZE-1:0] rdata_p1;

    always_ff @(posedge clk) begin
      if (rst)     rdata_p1 <= '0;
      else if (re) rdata_p1 <= mem[raddr];
    end

    assign rdata = rdata_p1;
  end

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// occupancy count and sticky overflow/underflow flags.
//   clk              in   clock, rising edge
//   rst              in   synchronous active-high reset
//   wr_data          in   write data
//   wr_inc           in   write request
//   wr_full          out  count == DEPTH
//   wr_almost_full   out  count >= AF_THRESH
//   rd_inc           in   read request (pops the head in FWFT mode)
//   rd_data          out  read data
//   rd_valid         out  STD: word popped last cycle; FWFT: FIFO not empty
//   rd_empty         out  count == 0
//   rd_almost_empty  out  count <= AE_THRESH
//   count            out  occupancy 0..DEPTH
//   overflow         out  sticky: write attempted while full
//   underflow        out  sticky: read attempted while empty
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 3,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] wr_data,
  input  logic             wr_inc,
  output logic             wr_full,
  output logic             wr_almost_full,
  input  logic             rd_inc,
  output logic [DSIZE-1:0] rd_data,
  output logic             rd_valid,
  output logic             rd_empty,
  output logic             rd_almost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int         DEPTH = fifo_depth(ASIZE);
  localparam fifo_mode_e MODE  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  localparam logic [ASIZE:0] DEPTH_C = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AF_C    = (ASIZE+1)'(AF_THRESH);
  localparam logic [ASIZE:0] AE_C    = (ASIZE+1)'(AE_THRESH);

  if (ASIZE < 1) begin : g_bad_asize
    $error("sync_fifo_prog: ASIZE must be at least 1");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_prog: AF_THRESH must lie in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_prog: AE_THRESH must lie in 0..DEPTH-1");
  end

  // One extra pointer bit separates full (MSBs differ) from empty (equal).
  logic [ASIZE:0] wptr;
  logic [ASIZE:0] rptr;
  logic           wr_en;
  logic           rd_en;

  // Flags depend only on the pointer registers, never on this cycle's requests.
  assign count           = wptr - rptr;
  assign wr_full         = (count == DEPTH_C);
  assign rd_empty        = (count == '0);
  assign wr_almost_full  = (count >= AF_C);
  assign rd_almost_empty = (count <= AE_C);

  // Acceptance uses pre-edge state, so at full a simultaneous read still
  // frees a slot but the write is rejected (and vice versa at empty).
  assign wr_en = wr_inc & ~wr_full & ~rst;
  assign rd_en = rd_inc & ~rd_empty & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en)              wptr      <= wptr + 1'b1;
      if (rd_en)              rptr      <= rptr + 1'b1;
      if (wr_inc && wr_full)  overflow  <= 1'b1;
      if (rd_inc && rd_empty) underflow <= 1'b1;
    end
  end

  sync_fifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE),
    .MODE  (MODE)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (wptr[ASIZE-1:0]),
    .wdata (wr_data),
    .re    (rd_en),
    .raddr (rptr[ASIZE-1:0]),
    .rdata (rd_data)
  );

  if (MODE == FIFO_FWFT) begin : g_fwft_vld
    assign rd_valid = ~rd_empty;
  end else begin : g_std_vld
    // Read stage boundary: valid follows the registered word out of the array.
    logic vld_p1;

    always_ff @(posedge clk) begin
      if (rst) vld_p1 <= 1'b0;
      else     vld_p1 <= rd_en;
    end

    assign rd_valid = vld_p1;
  end

endmodule
